// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encoding and default field sizes.
// Imported by the normalise/round/pack pipeline and its rounding unit.
package fp_pkg;

  localparam int DefExponentSize = 8;
  localparam int DefFractionSize = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } roundMode_e;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational mantissa rounder: applies the rounding-mode increment and reports
// mantissa carry-out (renormalisation needed) and inexactness.
module fp_round_unit
  import fp_pkg::*;
#(
  parameter int MantissaSize = DefFractionSize + 1
) (
  input  logic [MantissaSize-1:0] Mantissa,
  input  logic                    Guard,
  input  logic                    RoundBit,
  input  logic                    Sticky,
  input  logic                    Sign,
  input  roundMode_e              RoundMode,
  output logic [MantissaSize-1:0] RoundedMantissa,
  output logic                    CarryOut,
  output logic                    Inexact
);

  logic                  anyLost;
  logic                  increment;
  logic [MantissaSize:0] sum;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    anyLost   = Guard | RoundBit | Sticky;
    increment = 1'b0;
    case (RoundMode)
      RM_RNE:  increment = Guard & (Mantissa[0] | RoundBit | Sticky);
      RM_RTZ:  increment = 1'b0;
      RM_RUP:  increment = ~Sign & anyLost;
      RM_RDN:  increment = Sign & anyLost;
      default: increment = 1'b0;
    endcase

    sum      = {1'b0, Mantissa} + {{MantissaSize{1'b0}}, increment};
    CarryOut = sum[MantissaSize];
    // An all-ones mantissa rounding up becomes 1.000...; the exponent absorbs the carry.
    RoundedMantissa = CarryOut ? {1'b1, {(MantissaSize-1){1'b0}}} : sum[MantissaSize-1:0];
    Inexact         = anyLost;
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise/round/pack stage shared by the add/sub and multiply datapaths.
// Stage 1 selects and normalises the raw mantissa; stage 2 rounds, saturates and packs.
module fp_norm_round_pipe
  import fp_pkg::*;
#(
  parameter int ExponentSize = DefExponentSize,
  parameter int FractionSize = DefFractionSize
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic                               MULorADD,
  input  logic                               Sign,
  input  logic [1:0]                         RoundMode,
  input  logic [ExponentSize-1:0]            ExponentBase,
  input  logic                               EffCarry,
  input  logic [FractionSize+3:0]            AdderResult,
  input  logic [$clog2(FractionSize+4)-1:0]  NormShifts,
  input  logic [2*FractionSize+1:0]          MULResult,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [ExponentSize+FractionSize:0] Result,
  output logic                               Overflow,
  output logic                               Underflow,
  output logic                               Inexact
);

  localparam int MantissaSize = FractionSize + 1;
  localparam int RoundingSize = MantissaSize + 3;
  localparam int DataSize     = 1 + ExponentSize + FractionSize;
  localparam int ExpWide      = ExponentSize + 2;
  localparam int ProdTop      = 2 * MantissaSize - 1;

  localparam logic signed [ExpWide-1:0] ExpOverflow = ExpWide'((1 << ExponentSize) - 1);
  localparam logic signed [ExpWide-1:0] ExpZero     = '0;

  typedef struct packed {
    logic                    sign;
    roundMode_e              mode;
    logic                    zero;
    logic [ExpWide-1:0]      exp;
    logic [RoundingSize-1:0] bits;   // {hidden, fraction, G, R, S}
  } stage1_t;

  stage1_t s1Next, s1Q;
  logic    s1Valid, s2Valid;
  logic    s2Ready, s1Advance, inFire;
  logic [ExpWide-1:0] expDelta;

  assign s2Ready   = ~s2Valid | OutReady;
  assign s1Advance = s1Valid & s2Ready;
  assign InReady   = ~s1Valid | s2Ready;
  assign inFire    = InValid & InReady;
  assign OutValid  = s2Valid;

  // Stage 1: pick the mantissa source and align it to {hidden, fraction, G, R, S}.
  always_comb begin
    expDelta    = '0;
    s1Next.bits = '0;
    s1Next.zero = 1'b0;
    if (MULorADD) begin
      if (MULResult[ProdTop]) begin
        s1Next.bits = {MULResult[ProdTop -: MantissaSize+2], |MULResult[MantissaSize-3:0]};
      end else begin
        s1Next.bits = {MULResult[ProdTop-1 -: MantissaSize+2], |MULResult[MantissaSize-4:0]};
      end
      expDelta = ExpWide'(MULResult[ProdTop]);
    end else if (EffCarry) begin
      s1Next.bits = {1'b1, AdderResult[RoundingSize-1:2], AdderResult[1] | AdderResult[0]};
      expDelta    = ExpWide'(1);
    end else begin
      s1Next.bits = AdderResult << NormShifts;
      expDelta    = -(ExpWide'(NormShifts));
      s1Next.zero = (AdderResult == '0);
    end
    // Two guard bits above the exponent field keep +1 overflow and negative results unwrapped.
    s1Next.exp  = ExpWide'(ExponentBase) + expDelta;
    s1Next.sign = Sign;
    s1Next.mode = roundMode_e'(RoundMode);
  end

  // NOTE: the stage-1 payload has no reset; s1Valid alone qualifies it.
  always_ff @(posedge Clk) begin
    if (inFire) s1Q <= s1Next;
  end

  // Stage 2: round, renormalise on carry, saturate and pack.
  logic [MantissaSize-1:0] roundedMant;
  logic                    roundCarry;
  logic                    roundInexact;
  logic signed [ExpWide-1:0] expFinal;
  logic                    toInfinity;
  logic [DataSize-1:0]     resultNext;
  logic                    overflowNext, underflowNext, inexactNext;
  logic                    unusedHidden;

  fp_round_unit #(
    .MantissaSize(MantissaSize)
  ) uRound (
    .Mantissa       (s1Q.bits[RoundingSize-1:3]),
    .Guard          (s1Q.bits[2]),
    .RoundBit       (s1Q.bits[1]),
    .Sticky         (s1Q.bits[0]),
    .Sign           (s1Q.sign),
    .RoundMode      (s1Q.mode),
    .RoundedMantissa(roundedMant),
    .CarryOut       (roundCarry),
    .Inexact        (roundInexact)
  );

  assign expFinal     = $signed(s1Q.exp + ExpWide'(roundCarry));
  assign unusedHidden = roundedMant[MantissaSize-1];
  assign toInfinity   = (s1Q.mode == RM_RNE) ||
                        (s1Q.mode == RM_RUP && !s1Q.sign) ||
                        (s1Q.mode == RM_RDN && s1Q.sign);

  always_comb begin
    resultNext    = {s1Q.sign, expFinal[ExponentSize-1:0], roundedMant[FractionSize-1:0]};
    overflowNext  = 1'b0;
    underflowNext = 1'b0;
    inexactNext   = roundInexact;
    if (s1Q.zero) begin
      resultNext  = {s1Q.sign, {(DataSize-1){1'b0}}};
      inexactNext = 1'b0;
    end else if (expFinal >= ExpOverflow) begin
      overflowNext = 1'b1;
      inexactNext  = 1'b1;
      // Modes that round away from zero in this direction saturate to infinity, others to max-finite.
      resultNext = toInfinity ?
                   {s1Q.sign, {ExponentSize{1'b1}}, {FractionSize{1'b0}}} :
                   {s1Q.sign, {(ExponentSize-1){1'b1}}, 1'b0, {FractionSize{1'b1}}};
    end else if (expFinal <= ExpZero) begin
      underflowNext = 1'b1;
      inexactNext   = 1'b1;
      resultNext    = {s1Q.sign, {(DataSize-1){1'b0}}};
    end
  end

  // NOTE: registers update with <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1Valid   <= 1'b0;
      s2Valid   <= 1'b0;
      Result    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexact   <= 1'b0;
    end else begin
      if (InReady) s1Valid <= InValid;
      if (s2Ready) s2Valid <= s1Valid;
      if (s1Advance) begin
        Result    <= resultNext;
        Overflow  <= overflowNext;
        Underflow <= underflowNext;
        Inexact   <= inexactNext;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe: directed corner vectors, backpressure,
// asynchronous reset, and randomized traffic against an arithmetic reference model.
module tb_fp_norm_round_pipe;

  typedef struct packed {
    logic        mul;
    logic        sign;
    logic [1:0]  rm;
    logic [7:0]  eb;
    logic        carry;
    logic [26:0] ar;
    logic [4:0]  ns;
    logic [47:0] mr;
  } beat_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        MULorADD = 1'b0;
  logic        Sign = 1'b0;
  logic [1:0]  RoundMode = 2'b00;
  logic [7:0]  ExponentBase = '0;
  logic        EffCarry = 1'b0;
  logic [26:0] AdderResult = '0;
  logic [4:0]  NormShifts = '0;
  logic [47:0] MULResult = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] Result;
  logic        Overflow, Underflow, Inexact;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 Clk = ~Clk;

  fp_norm_round_pipe #(
    .ExponentSize(8),
    .FractionSize(23)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .MULorADD    (MULorADD),
    .Sign        (Sign),
    .RoundMode   (RoundMode),
    .ExponentBase(ExponentBase),
    .EffCarry    (EffCarry),
    .AdderResult (AdderResult),
    .NormShifts  (NormShifts),
    .MULResult   (MULResult),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .Overflow    (Overflow),
    .Underflow   (Underflow),
    .Inexact     (Inexact)
  );

  // Reference: value-level normalise then round-to-integer of the kept significand.
  function automatic logic [34:0] model(input beat_t b);
    longint unsigned v, keep, rem, half;
    int e;
    logic up, toInf;
    logic [31:0] res;
    if (!b.mul && !b.carry && b.ar == 27'd0) return {b.sign, 31'd0, 3'b000};
    if (b.mul) begin
      v = 64'(b.mr);
      if (b.mr[47]) begin
        keep = v >> 24; rem = v & 64'hFF_FFFF; half = 64'h80_0000; e = int'(b.eb) + 1;
      end else begin
        keep = (v >> 23) & 64'hFF_FFFF; rem = v & 64'h7F_FFFF; half = 64'h40_0000; e = int'(b.eb);
      end
    end else if (b.carry) begin
      v = (64'd1 << 27) | 64'(b.ar);
      keep = v >> 4; rem = v & 64'hF; half = 64'h8; e = int'(b.eb) + 1;
    end else begin
      v = (64'(b.ar) << b.ns) & 64'h7FF_FFFF;
      keep = v >> 3; rem = v & 64'h7; half = 64'h4; e = int'(b.eb) - int'(b.ns);
    end
    case (b.rm)
      2'd0:    up = (rem > half) || (rem == half && keep[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !b.sign && rem != 0;
      default: up = b.sign && rem != 0;
    endcase
    keep = keep + 64'(up);
    if (keep == 64'h100_0000) begin
      keep = 64'h80_0000;
      e = e + 1;
    end
    if (e >= 255) begin
      toInf = (b.rm == 2'd0) || (b.rm == 2'd2 && !b.sign) || (b.rm == 2'd3 && b.sign);
      res = toInf ? {b.sign, 8'hFF, 23'd0} : {b.sign, 8'hFE, 23'h7FFFFF};
      return {res, 3'b101};
    end
    if (e <= 0) return {b.sign, 31'd0, 3'b011};
    res = {b.sign, 8'(e), keep[22:0]};
    return {res, 2'b00, rem != 0};
  endfunction

  function automatic beat_t mk(input logic mul, input logic sign, input logic [1:0] rm,
                               input logic [7:0] eb, input logic carry, input logic [26:0] ar,
                               input logic [4:0] ns, input logic [47:0] mr);
    beat_t b;
    b.mul = mul; b.sign = sign; b.rm = rm; b.eb = eb;
    b.carry = carry; b.ar = ar; b.ns = ns; b.mr = mr;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.mul  = 1'($urandom_range(0, 1));
    b.sign = 1'($urandom_range(0, 1));
    b.rm   = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0:       b.eb = 8'($urandom_range(250, 255));
      1:       b.eb = 8'($urandom_range(0, 6));
      default: b.eb = 8'($urandom_range(1, 254));
    endcase
    b.carry = 1'($urandom_range(0, 1));
    b.ar    = 27'($urandom);
    b.ns    = 5'($urandom_range(0, 26));
    case ($urandom_range(0, 7))
      0: b.ar = '0;
      1: begin b.ar = 27'h7FFFFF8 | 27'($urandom_range(0, 7)); b.ns = '0; end
      2: b.ns = 5'($urandom_range(0, 31));
      default: ;
    endcase
    b.mr = {16'($urandom), 32'($urandom)};
    if ($urandom_range(0, 7) != 0) b.mr[47:46] = 2'($urandom_range(1, 3));
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    MULorADD = b.mul; Sign = b.sign; RoundMode = b.rm; ExponentBase = b.eb;
    EffCarry = b.carry; AdderResult = b.ar; NormShifts = b.ns; MULResult = b.mr;
  endtask

  // Offers one beat into an empty pipe and waits (bounded) for its result.
  task automatic send_one(input beat_t b, output logic [34:0] got, output int lat);
    @(negedge Clk);
    drive_beat(b);
    InValid  = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    got = {Result, Overflow, Underflow, Inexact};
  endtask

  task automatic test_reset();
    Rst_n = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    nVectors++;
    if (OutValid !== 1'b0) begin nMiscompares++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    nVectors++;
    if (InReady !== 1'b1) begin nMiscompares++; $display("FAIL reset_inready got=%b exp=1", InReady); end
    nVectors++;
    if ({Result, Overflow, Underflow, Inexact} !== 35'd0) begin
      nMiscompares++;
      $display("FAIL reset_outputs got=%h exp=0", {Result, Overflow, Underflow, Inexact});
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    nVectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      nMiscompares++;
      $display("FAIL post_reset got valid=%b ready=%b exp valid=0 ready=1", OutValid, InReady);
    end
  endtask

  task automatic test_directed();
    beat_t       vec[16];
    logic [34:0] want[16];
    logic [34:0] got;
    int          lat;
    vec[0]  = mk(0, 0, 2'd0, 8'd127, 1, 27'h0,       5'd0, 48'h0);            want[0]  = {32'h40000000, 3'b000};
    vec[1]  = mk(1, 0, 2'd0, 8'd127, 0, 27'h0,       5'd0, 48'h900000000000); want[1]  = {32'h40100000, 3'b000};
    vec[2]  = mk(0, 0, 2'd0, 8'd127, 0, 27'h4000004, 5'd0, 48'h0);            want[2]  = {32'h3F800000, 3'b001};
    vec[3]  = mk(0, 0, 2'd2, 8'd127, 0, 27'h4000004, 5'd0, 48'h0);            want[3]  = {32'h3F800001, 3'b001};
    vec[4]  = mk(0, 0, 2'd0, 8'd127, 0, 27'h7FFFFFC, 5'd0, 48'h0);            want[4]  = {32'h40000000, 3'b001};
    vec[5]  = mk(0, 0, 2'd0, 8'd254, 1, 27'h0,       5'd0, 48'h0);            want[5]  = {32'h7F800000, 3'b101};
    vec[6]  = mk(0, 0, 2'd1, 8'd254, 1, 27'h0,       5'd0, 48'h0);            want[6]  = {32'h7F7FFFFF, 3'b101};
    vec[7]  = mk(0, 1, 2'd3, 8'd254, 1, 27'h0,       5'd0, 48'h0);            want[7]  = {32'hFF800000, 3'b101};
    vec[8]  = mk(0, 1, 2'd2, 8'd254, 1, 27'h0,       5'd0, 48'h0);            want[8]  = {32'hFF7FFFFF, 3'b101};
    vec[9]  = mk(0, 1, 2'd0, 8'd100, 0, 27'h0,       5'd0, 48'h0);            want[9]  = {32'h80000000, 3'b000};
    vec[10] = mk(0, 0, 2'd0, 8'd3,   0, 27'h0400000, 5'd4, 48'h0);            want[10] = {32'h00000000, 3'b011};
    vec[11] = mk(0, 0, 2'd0, 8'd254, 0, 27'h4000000, 5'd0, 48'h0);            want[11] = {32'h7F000000, 3'b000};
    vec[12] = mk(0, 0, 2'd0, 8'd1,   0, 27'h4000000, 5'd0, 48'h0);            want[12] = {32'h00800000, 3'b000};
    vec[13] = mk(0, 0, 2'd0, 8'd0,   0, 27'h4000000, 5'd0, 48'h0);            want[13] = {32'h00000000, 3'b011};
    vec[14] = mk(1, 0, 2'd0, 8'd127, 0, 27'h0,       5'd0, 48'h400000000000); want[14] = {32'h3F800000, 3'b000};
    vec[15] = mk(0, 1, 2'd3, 8'd127, 0, 27'h4000001, 5'd0, 48'h0);            want[15] = {32'hBF800001, 3'b001};
    for (int i = 0; i < 16; i++) begin
      send_one(vec[i], got, lat);
      nVectors++;
      if (lat !== 2) begin
        nMiscompares++;
        $display("FAIL directed_latency[%0d] got=%0d exp=2", i, lat);
      end
      nVectors++;
      if (got !== want[i]) begin
        nMiscompares++;
        $display("FAIL directed[%0d] got result=%h ovf/unf/inx=%b exp result=%h ovf/unf/inx=%b",
                 i, got[34:3], got[2:0], want[i][34:3], want[i][2:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t       a, b, c;
    logic [34:0] q[$];
    logic [34:0] want;
    logic        cAccepted;
    a = rand_beat(); b = rand_beat(); c = rand_beat();
    @(negedge Clk);
    OutReady = 1'b0;
    drive_beat(a); InValid = 1'b1;
    #1;
    nVectors++;
    if (InReady !== 1'b1) begin nMiscompares++; $display("FAIL bp_accept_a got=%b exp=1", InReady); end
    q.push_back(model(a));
    @(negedge Clk);
    drive_beat(b);
    #1;
    nVectors++;
    if (InReady !== 1'b1) begin nMiscompares++; $display("FAIL bp_accept_b got=%b exp=1", InReady); end
    q.push_back(model(b));
    @(negedge Clk);
    drive_beat(c);
    #1;
    nVectors++;
    if (InReady !== 1'b0) begin nMiscompares++; $display("FAIL bp_full_ready got=%b exp=0", InReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      nVectors++;
      if (InReady !== 1'b0 || OutValid !== 1'b1 || {Result, Overflow, Underflow, Inexact} !== q[0]) begin
        nMiscompares++;
        $display("FAIL bp_hold[%0d] got ready=%b valid=%b out=%h exp ready=0 valid=1 out=%h",
                 i, InReady, OutValid, {Result, Overflow, Underflow, Inexact}, q[0]);
      end
    end
    cAccepted = 1'b0;
    for (int cyc = 0; cyc < 20 && (q.size() > 0 || !cAccepted); cyc++) begin
      @(negedge Clk);
      if (cAccepted) InValid = 1'b0;
      OutReady = 1'b1;
      #1;
      if (OutValid) begin
        want = q.pop_front();
        nVectors++;
        if ({Result, Overflow, Underflow, Inexact} !== want) begin
          nMiscompares++;
          $display("FAIL bp_order got=%h exp=%h", {Result, Overflow, Underflow, Inexact}, want);
        end
      end
      if (InValid && InReady && !cAccepted) begin
        q.push_back(model(c));
        cAccepted = 1'b1;
      end
    end
    @(negedge Clk);
    InValid = 1'b0;
    nVectors++;
    if (q.size() != 0 || !cAccepted) begin
      nMiscompares++;
      $display("FAIL bp_drain got pending=%0d c_accepted=%b exp pending=0 c_accepted=1", q.size(), cAccepted);
    end
  endtask

  task automatic test_random(input int nBeats);
    beat_t       cur;
    logic        have;
    int          sent, cycles;
    logic [34:0] q[$];
    logic [34:0] want;
    logic        wantReady;
    have = 1'b0; sent = 0; cycles = 0;
    cur = rand_beat();
    while ((sent < nBeats || q.size() > 0) && cycles < nBeats * 20) begin
      @(negedge Clk);
      if (!have) InValid = 1'b0;
      OutReady = ($urandom_range(0, 3) != 0);
      if (!have && sent < nBeats && $urandom_range(0, 4) != 0) begin
        cur = rand_beat();
        drive_beat(cur);
        InValid = 1'b1;
        have = 1'b1;
      end
      #1;
      // At most two beats in flight; with both slots full only downstream readiness frees one.
      wantReady = (q.size() < 2) || OutReady;
      nVectors++;
      if (InReady !== wantReady) begin
        nMiscompares++;
        $display("FAIL random_inready got=%b exp=%b in_flight=%0d", InReady, wantReady, q.size());
      end
      if (OutValid && OutReady) begin
        nVectors++;
        if (q.size() == 0) begin
          nMiscompares++;
          $display("FAIL random_spurious got=%h exp=no output", {Result, Overflow, Underflow, Inexact});
        end else begin
          want = q.pop_front();
          if ({Result, Overflow, Underflow, Inexact} !== want) begin
            nMiscompares++;
            $display("FAIL random_result got=%h flags=%b exp=%h flags=%b",
                     Result, {Overflow, Underflow, Inexact}, want[34:3], want[2:0]);
          end
        end
      end
      if (InValid && InReady) begin
        q.push_back(model(cur));
        sent++;
        have = 1'b0;
      end
      cycles++;
    end
    @(negedge Clk);
    InValid = 1'b0;
    nVectors++;
    if (sent != nBeats || q.size() != 0) begin
      nMiscompares++;
      $display("FAIL random_timeout got sent=%0d pending=%0d exp sent=%0d pending=0", sent, q.size(), nBeats);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge Clk);
    OutReady = 1'b0;
    drive_beat(rand_beat()); InValid = 1'b1;
    @(negedge Clk);
    drive_beat(rand_beat());
    @(negedge Clk);
    InValid = 1'b0;
    #1;
    nVectors++;
    if (OutValid !== 1'b1) begin nMiscompares++; $display("FAIL midreset_prefill got=%b exp=1", OutValid); end
    #2 Rst_n = 1'b0;
    #1;
    nVectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      nMiscompares++;
      $display("FAIL midreset_async got valid=%b ready=%b exp valid=0 ready=1", OutValid, InReady);
    end
    nVectors++;
    if ({Result, Overflow, Underflow, Inexact} !== 35'd0) begin
      nMiscompares++;
      $display("FAIL midreset_outputs got=%h exp=0", {Result, Overflow, Underflow, Inexact});
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    nVectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      nMiscompares++;
      $display("FAIL midreset_release got valid=%b ready=%b exp valid=0 ready=1", OutValid, InReady);
    end
    OutReady = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(400);
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
